ysyx_22050019_lsu_stage: RTL and testbench
==========================================

// Module: ysyx_22050019_lsu_stage
// PURPOSE
//  Load/store unit stage between EX/MEM and MEM_WB; drives the LSU writeback inputs of MEM_WB.
//  Accepts one memory op at a time from EX and runs a valid/ready request to the 64-bit data bus.
//  Aligns store data and strobes, then extracts and sign/zero-extends load data.
//  Stalls upstream while busy.
// PARAMETERS
//  AW  64  address width
//  DW  64  data bus width; fixed at 64, other values unsupported
// PORTS
//  clk               in   1   clock
//  rst_n             in   1   reset, synchronous, active-low
//  ex_valid_i        in   1   EX presents an instruction this cycle
//  ex_mem_ren_i      in   1   instruction is a load
//  ex_mem_wen_i      in   1   instruction is a store; wins if ren also high
//  ex_funct3_i       in   3   RV64 load/store funct3
//  ex_addr_i         in   64  effective address
//  ex_wdata_i        in   64  store data (rs2)
//  ex_rd_i           in   5   load destination register
//  mem_req_valid_o   out  1   bus request valid
//  mem_req_ready_i   in   1   bus accepts request
//  mem_req_addr_o    out  64  request address, {addr[63:3],3'b0}
//  mem_req_wen_o     out  1   1=write
//  mem_req_wdata_o   out  64  lane-shifted store data
//  mem_req_wstrb_o   out  8   byte strobes
//  mem_resp_valid_i  in   1   read data / write ack
//  mem_resp_rdata_i  in   64  read data
//  lsu_stall_o       out  1   hold upstream
//  lsu_done_o        out  1   one-cycle op-complete pulse
//  reg_we_lsu_o      out  1   to MEM_WB reg_we_lsu_i
//  reg_waddr_lsu_o   out  5   to MEM_WB reg_waddr_lsu_i
//  reg_wdata_lsu_o   out  64  to MEM_WB reg_wdata_lsu_i
//  lsu_fault_o       out  1   misaligned-access pulse (LSU_MISALIGN_CHECK_EN only)
//  lsu_fault_addr_o  out  64  faulting address (LSU_MISALIGN_CHECK_EN only)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0.
//  FSM IDLE -> REQ -> RESP -> IDLE.
//   IDLE: ex_valid_i & (ren|wen) latches op/addr/data/rd/funct3 and goes to REQ.
//   REQ: mem_req_valid_o=1, all req fields held stable; on ready -> RESP.
//   RESP: waits mem_resp_valid_i; on it -> IDLE.
//  Response is ignored in IDLE/REQ and in the same cycle as the handshake.
//  lsu_stall_o = (state!=IDLE) | (IDLE & ex_valid_i & (ren|wen)); purely combinational.
//  Completion outputs are registered and valid one cycle after the resp cycle, for exactly one cycle.
//   That cycle has state=IDLE and stall low, so a new op can be accepted.
//  Minimum latency is 3 cycles from accept to lsu_done_o.
//  off=addr[2:0]; mem_req_wdata_o = wdata<<(8*off).
//  wstrb: SB 8'h01<<off, SH 8'h03<<off, SW 8'h0F<<off, SD 8'hFF; bits shifted past bit 7 are dropped.
//  Load: r = rdata>>(8*off).
//   funct3 000 LB, 001 LH, 010 LW: sign-extend 8/16/32 bits.
//   funct3 011 LD: r as-is.
//   funct3 100 LBU, 101 LHU, 110 LWU: zero-extend.
//   funct3 111: result 0, reg_we still 1.
//  Load done: reg_we=(rd!=0), waddr=rd, wdata=value. rd=0 drives we, waddr and wdata all 0.
//  Store done: lsu_done_o=1 only.
//  reg_we/waddr/wdata are 0 in every cycle without a load completion; MEM_WB ORs them with the EX path.
//  Reset mid-op: FSM returns to IDLE, outputs are cleared, no done pulse.
//   A stale mem_resp_valid_i after reset is ignored.
// CONFIGURATION
//  LSU_MISALIGN_CHECK_EN defined:
//   Misaligned means H with off[0]!=0, W with off[1:0]!=0, or D with off!=0.
//   A misaligned op issues no bus request. FSM goes IDLE->IDLE with stall high in the accept cycle.
//   Next cycle: lsu_done_o=1, lsu_fault_o=1, lsu_fault_addr_o=ex addr, reg_we=0.
//  Undefined: fault ports tied 0; misaligned ops proceed with truncated strobes/data as above.
// TESTING
//  1 LB addr 0x80000003, rd=5, rdata 0x0123456789ABCDEF -> addr_o 0x80000000, wdata_lsu 0xFFFFFFFFFFFFFF89, we=1, waddr=5.
//    LBU with the same stimulus -> 0x89.
//  2 SH addr 0x80000006, wdata 0xBEEF -> wen=1, wstrb 8'hC0, wdata_o 0xBEEF000000000000, no reg_we.
//  3 mem_req_ready_i low for 4 cycles -> req_valid/addr/wdata stable and stall=1 throughout; exactly one lsu_done_o.
//  4 LD rd=0 -> lsu_done_o=1, reg_we=0, waddr=0, wdata=0.
//  5 rst_n low in RESP, then resp_valid high -> all outputs 0, no done, next op runs normally.
//  6 (LSU_MISALIGN_CHECK_EN) LW addr 0x80000002 -> no mem_req_valid_o, next cycle done=1, fault=1, fault_addr=0x80000002.

Source files
------------

// File: rtl/ysyx_22050019_lsu_stage.sv
// Load/store unit stage: one memory op at a time over a valid/ready 64-bit data bus, feeding MEM_WB.
// Optional misaligned-access trapping is enabled by defining LSU_MISALIGN_CHECK_EN.
module ysyx_22050019_lsu_stage #(
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ex_valid_i,
    input  logic          ex_mem_ren_i,
    input  logic          ex_mem_wen_i,
    input  logic [2:0]    ex_funct3_i,
    input  logic [AW-1:0] ex_addr_i,
    input  logic [DW-1:0] ex_wdata_i,
    input  logic [4:0]    ex_rd_i,
    output logic          mem_req_valid_o,
    input  logic          mem_req_ready_i,
    output logic [AW-1:0] mem_req_addr_o,
    output logic          mem_req_wen_o,
    output logic [DW-1:0] mem_req_wdata_o,
    output logic [DW/8-1:0] mem_req_wstrb_o,
    input  logic          mem_resp_valid_i,
    input  logic [DW-1:0] mem_resp_rdata_i,
    output logic          lsu_stall_o,
    output logic          lsu_done_o,
    output logic          reg_we_lsu_o,
    output logic [4:0]    reg_waddr_lsu_o,
    output logic [DW-1:0] reg_wdata_lsu_o,
    output logic          lsu_fault_o,
    output logic [AW-1:0] lsu_fault_addr_o
);

    localparam int SW = DW / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic          op_wen_q;
    logic [2:0]    funct3_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [4:0]    rd_q;

    logic          done_q;
    logic          reg_we_q;
    logic [4:0]    reg_waddr_q;
    logic [DW-1:0] reg_wdata_q;

    logic accept;
    logic mis;
    logic resp_fire;
    logic load_wb;

    function automatic logic [DW-1:0] store_align(input logic [DW-1:0] wdata,
                                                  input logic [2:0]    off);
        return wdata << {off, 3'b000};
    endfunction

    // Bits shifted past the top lane are intentionally lost (no split accesses).
    function automatic logic [SW-1:0] store_strobe(input logic [2:0] f3,
                                                   input logic [2:0] off);
        logic [SW-1:0] s;
        case (f3[1:0])
            2'b00:   s = 8'h01 << off;
            2'b01:   s = 8'h03 << off;
            2'b10:   s = 8'h0F << off;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    function automatic logic [DW-1:0] load_extract(input logic [DW-1:0] rdata,
                                                   input logic [2:0]    off,
                                                   input logic [2:0]    f3);
        logic        [DW-1:0] r;
        logic signed [DW-1:0] v;
        r = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  v = {{56{r[7]}},  r[7:0]};
            3'b001:  v = {{48{r[15]}}, r[15:0]};
            3'b010:  v = {{32{r[31]}}, r[31:0]};
            3'b011:  v = r;
            3'b100:  v = {56'd0, r[7:0]};
            3'b101:  v = {48'd0, r[15:0]};
            3'b110:  v = {32'd0, r[31:0]};
            default: v = '0;
        endcase
        return v;
    endfunction

    assign accept    = (state_q == IDLE) & ex_valid_i & (ex_mem_ren_i | ex_mem_wen_i);
    assign resp_fire = (state_q == RESP) & mem_resp_valid_i;
    assign load_wb   = resp_fire & ~op_wen_q & (rd_q != 5'd0);

`ifdef LSU_MISALIGN_CHECK_EN
    logic          fault_q;
    logic [AW-1:0] fault_addr_q;

    function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] off);
        logic m;
        case (f3)
            3'b001, 3'b101: m = off[0];
            3'b010, 3'b110: m = (off[1:0] != 2'b00);
            3'b011:         m = (off != 3'b000);
            default:        m = 1'b0;
        endcase
        return m;
    endfunction

    assign mis = accept & misaligned(ex_funct3_i, ex_addr_i[2:0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            fault_q      <= mis;
            fault_addr_q <= mis ? ex_addr_i : '0;
        end
    end

    assign lsu_fault_o      = fault_q;
    assign lsu_fault_addr_o = fault_addr_q;
`else
    assign mis              = 1'b0;
    assign lsu_fault_o      = 1'b0;
    assign lsu_fault_addr_o = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept && !mis) state_d = REQ;
            REQ:     if (mem_req_ready_i) state_d = RESP;
            RESP:    if (mem_resp_valid_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Op capture: only consumed while the FSM is busy, so left unreset.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_wen_q <= ex_mem_wen_i;
            funct3_q <= ex_funct3_i;
            addr_q   <= ex_addr_i;
            wdata_q  <= ex_wdata_i;
            rd_q     <= ex_rd_i;
        end
    end

    // Completion stage: one-cycle pulse after the response, zero otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_q      <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
        end else begin
            done_q      <= resp_fire | mis;
            reg_we_q    <= load_wb;
            reg_waddr_q <= load_wb ? rd_q : 5'd0;
            reg_wdata_q <= load_wb ? load_extract(mem_resp_rdata_i, addr_q[2:0], funct3_q) : '0;
        end
    end

    always_comb begin
        mem_req_valid_o = 1'b0;
        mem_req_addr_o  = '0;
        mem_req_wen_o   = 1'b0;
        mem_req_wdata_o = '0;
        mem_req_wstrb_o = '0;
        if (state_q == REQ) begin
            mem_req_valid_o = 1'b1;
            mem_req_addr_o  = {addr_q[AW-1:3], 3'b000};
            mem_req_wen_o   = op_wen_q;
            if (op_wen_q) begin
                mem_req_wdata_o = store_align(wdata_q, addr_q[2:0]);
                mem_req_wstrb_o = store_strobe(funct3_q, addr_q[2:0]);
            end
        end
    end

    assign lsu_stall_o     = (state_q != IDLE) | accept;
    assign lsu_done_o      = done_q;
    assign reg_we_lsu_o    = reg_we_q;
    assign reg_waddr_lsu_o = reg_waddr_q;
    assign reg_wdata_lsu_o = reg_wdata_q;

endmodule

// File: tb/tb_ysyx_22050019_lsu_stage.sv
// Self-checking bench for ysyx_22050019_lsu_stage: directed cases then randomized ops
// against a byte-level reference model.
module tb_ysyx_22050019_lsu_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid_i, ex_mem_ren_i, ex_mem_wen_i;
    logic [2:0]  ex_funct3_i;
    logic [63:0] ex_addr_i, ex_wdata_i;
    logic [4:0]  ex_rd_i;
    logic        mem_req_valid_o, mem_req_ready_i, mem_req_wen_o;
    logic [63:0] mem_req_addr_o, mem_req_wdata_o;
    logic [7:0]  mem_req_wstrb_o;
    logic        mem_resp_valid_i;
    logic [63:0] mem_resp_rdata_i;
    logic        lsu_stall_o, lsu_done_o, reg_we_lsu_o, lsu_fault_o;
    logic [4:0]  reg_waddr_lsu_o;
    logic [63:0] reg_wdata_lsu_o, lsu_fault_addr_o;

    int checks = 0;
    int passes = 0;

    ysyx_22050019_lsu_stage dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid_i(ex_valid_i), .ex_mem_ren_i(ex_mem_ren_i), .ex_mem_wen_i(ex_mem_wen_i),
        .ex_funct3_i(ex_funct3_i), .ex_addr_i(ex_addr_i), .ex_wdata_i(ex_wdata_i), .ex_rd_i(ex_rd_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_addr_o(mem_req_addr_o), .mem_req_wen_o(mem_req_wen_o),
        .mem_req_wdata_o(mem_req_wdata_o), .mem_req_wstrb_o(mem_req_wstrb_o),
        .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_rdata_i(mem_resp_rdata_i),
        .lsu_stall_o(lsu_stall_o), .lsu_done_o(lsu_done_o),
        .reg_we_lsu_o(reg_we_lsu_o), .reg_waddr_lsu_o(reg_waddr_lsu_o),
        .reg_wdata_lsu_o(reg_wdata_lsu_o),
        .lsu_fault_o(lsu_fault_o), .lsu_fault_addr_o(lsu_fault_addr_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Reference: gather the accessed bytes starting at the lane offset; lanes past byte 7 read as 0.
    function automatic logic [63:0] ref_load(input logic [63:0] rdata, input logic [63:0] addr,
                                             input logic [2:0] f3);
        logic [63:0] v;
        int off, n;
        v = '0;
        off = int'(addr[2:0]);
        n = 1 << f3[1:0];
        if (f3 == 3'b111) return '0;
        for (int i = 0; i < n; i++)
            if (off + i < 8) v[8*i +: 8] = rdata[8*(off+i) +: 8];
        if (!f3[2] && n < 8)
            for (int b = 8*n; b < 64; b++) v[b] = v[8*n-1];
        return v;
    endfunction

    function automatic logic [7:0] ref_strb(input logic [63:0] addr, input logic [2:0] f3);
        logic [7:0] s;
        int off, n;
        off = int'(addr[2:0]);
        n = 1 << f3[1:0];
        if (n == 8) return 8'hFF;
        for (int i = 0; i < 8; i++) s[i] = (i >= off) && (i < off + n);
        return s;
    endfunction

    function automatic bit ref_mis(input logic [63:0] addr, input logic [2:0] f3);
        int n;
        if (f3 == 3'b111) return 1'b0;
        n = 1 << f3[1:0];
        return (int'(addr[2:0]) % n) != 0;
    endfunction

    task automatic check_idle_zero(input string tag);
        chk({tag, "_done"}, lsu_done_o, 0);
        chk({tag, "_we"}, reg_we_lsu_o, 0);
        chk({tag, "_waddr"}, reg_waddr_lsu_o, 0);
        chk({tag, "_wdata"}, reg_wdata_lsu_o, 0);
        chk({tag, "_reqv"}, mem_req_valid_o, 0);
        chk({tag, "_stall"}, lsu_stall_o, 0);
        chk({tag, "_fault"}, lsu_fault_o, 0);
    endtask

    task automatic do_op(input bit wen, input bit ren, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wdata, input logic [4:0] rd,
                         input logic [63:0] rdata, input int pdly, input int rdly);
        bit exp_we;
        bit mis;
        logic [63:0] exp_wd;
        mis = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        mis = ref_mis(addr, f3);
`endif
        exp_we = !wen && (rd != 5'd0);
        exp_wd = exp_we ? ref_load(rdata, addr, f3) : 64'd0;
        ex_valid_i = 1'b1; ex_mem_ren_i = ren; ex_mem_wen_i = wen;
        ex_funct3_i = f3; ex_addr_i = addr; ex_wdata_i = wdata; ex_rd_i = rd;
        #1;
        chk("accept_stall", lsu_stall_o, 1);
        chk("accept_noreq", mem_req_valid_o, 0);
        tick();
        ex_valid_i = 1'b0; ex_mem_ren_i = 1'b0; ex_mem_wen_i = 1'b0;
        ex_addr_i = {$urandom, $urandom}; ex_wdata_i = {$urandom, $urandom};
        ex_rd_i = 5'($urandom); ex_funct3_i = 3'($urandom);
        #1;
        if (mis) begin
            chk("mis_noreq", mem_req_valid_o, 0);
            chk("mis_done", lsu_done_o, 1);
            chk("mis_fault", lsu_fault_o, 1);
            chk("mis_faddr", lsu_fault_addr_o, addr);
            chk("mis_we", reg_we_lsu_o, 0);
            chk("mis_stall", lsu_stall_o, 0);
            tick();
            chk("mis_done_end", lsu_done_o, 0);
            chk("mis_fault_end", lsu_fault_o, 0);
            return;
        end
        for (int k = 0; k <= pdly; k++) begin
            chk("req_valid", mem_req_valid_o, 1);
            chk("req_addr", mem_req_addr_o, {addr[63:3], 3'b000});
            chk("req_wen", mem_req_wen_o, wen);
            if (wen) begin
                chk("req_wdata", mem_req_wdata_o, wdata << (8 * addr[2:0]));
                chk("req_wstrb", mem_req_wstrb_o, ref_strb(addr, f3));
            end
            chk("req_stall", lsu_stall_o, 1);
            chk("req_nodone", lsu_done_o, 0);
            if (k == pdly) begin
                mem_req_ready_i = 1'b1;
                mem_resp_valid_i = 1'b1;
                mem_resp_rdata_i = {$urandom, $urandom};
            end
            tick();
        end
        mem_req_ready_i = 1'b0;
        mem_resp_valid_i = 1'b0;
        #1;
        for (int k = 0; k <= rdly; k++) begin
            chk("resp_stall", lsu_stall_o, 1);
            chk("resp_noreq", mem_req_valid_o, 0);
            chk("resp_nodone", lsu_done_o, 0);
            if (k == rdly) begin
                mem_resp_valid_i = 1'b1;
                mem_resp_rdata_i = rdata;
            end
            tick();
        end
        mem_resp_valid_i = 1'b0;
        mem_resp_rdata_i = {$urandom, $urandom};
        #1;
        chk("done", lsu_done_o, 1);
        chk("done_we", reg_we_lsu_o, exp_we);
        chk("done_waddr", reg_waddr_lsu_o, exp_we ? rd : 5'd0);
        chk("done_wdata", reg_wdata_lsu_o, exp_wd);
        chk("done_stall", lsu_stall_o, 0);
        chk("done_fault", lsu_fault_o, 0);
        tick();
        chk("post_done", lsu_done_o, 0);
        chk("post_we", reg_we_lsu_o, 0);
        chk("post_wdata", reg_wdata_lsu_o, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        ex_valid_i = 1'b0; ex_mem_ren_i = 1'b0; ex_mem_wen_i = 1'b0;
        ex_funct3_i = '0; ex_addr_i = '0; ex_wdata_i = '0; ex_rd_i = '0;
        mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_resp_rdata_i = '0;
        tick();
        tick();
        check_idle_zero("reset");
        chk("reset_faddr", lsu_fault_addr_o, 0);
        rst_n = 1'b1;
        tick();

        // Directed cases
        do_op(1'b0, 1'b1, 3'b000, 64'h80000003, 64'h0, 5'd5, 64'h0123456789ABCDEF, 0, 0);
        do_op(1'b0, 1'b1, 3'b100, 64'h80000003, 64'h0, 5'd5, 64'h0123456789ABCDEF, 0, 0);
        do_op(1'b1, 1'b0, 3'b001, 64'h80000006, 64'hBEEF, 5'd7, 64'h0, 0, 1);
        do_op(1'b0, 1'b1, 3'b010, 64'h80000010, 64'h0, 5'd9, 64'hCAFEF00D_87654321, 4, 2);
        do_op(1'b0, 1'b1, 3'b011, 64'h80000008, 64'h0, 5'd0, 64'hFFFF_0000_1234_5678, 1, 0);
        do_op(1'b1, 1'b1, 3'b011, 64'h80000020, 64'h1122334455667788, 5'd3, 64'h0, 0, 0);
        do_op(1'b0, 1'b1, 3'b111, 64'h80000000, 64'h0, 5'd12, 64'hDEADBEEF_DEADBEEF, 0, 0);
`ifdef LSU_MISALIGN_CHECK_EN
        do_op(1'b0, 1'b1, 3'b010, 64'h80000002, 64'h0, 5'd4, 64'h0, 0, 0);
`else
        do_op(1'b0, 1'b1, 3'b001, 64'h80000007, 64'h0, 5'd4, 64'h8000_0000_0000_0000, 0, 0);
        do_op(1'b1, 1'b0, 3'b010, 64'h80000006, 64'hA1B2C3D4, 5'd1, 64'h0, 0, 0);
`endif

        // Reset while waiting for the response; a stale response afterwards is ignored
        ex_valid_i = 1'b1; ex_mem_ren_i = 1'b1; ex_funct3_i = 3'b011;
        ex_addr_i = 64'h80000040; ex_rd_i = 5'd6;
        tick();
        ex_valid_i = 1'b0; ex_mem_ren_i = 1'b0;
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        rst_n = 1'b0;
        mem_resp_valid_i = 1'b1;
        mem_resp_rdata_i = 64'h5555AAAA5555AAAA;
        tick();
        check_idle_zero("rst_mid");
        rst_n = 1'b1;
        tick();
        check_idle_zero("rst_stale");
        mem_resp_valid_i = 1'b0;
        tick();
        do_op(1'b0, 1'b1, 3'b001, 64'h80000044, 64'h0, 5'd6, 64'h0000_0000_8001_0000, 1, 1);

        // Randomized ops
        for (int n = 0; n < 24; n++) begin
            bit w, r;
            logic [2:0] f;
            w = 1'($urandom);
            r = w ? 1'($urandom) : 1'b1;
            f = w ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            do_op(w, r, f, {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom),
                  {$urandom, $urandom}, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
